// File: rtl/rs232_recv.sv
// RS232 8N1 receiver: synchronizes rs232_txd, samples each bit at its computed centre, emits bytes on valid/ready.
// Latency: valid rises S_9+1 clock cycles after the synchronized falling edge of the start bit.
// Backpressure: single-byte buffer; cts_n goes high while a byte is pending, a byte completing into a full buffer is dropped with an overrun pulse.
module rs232_recv #(
    parameter int CLOCK_FREQ = 133000000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rs232_txd,
    output logic       rs232_cts_n,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       framing_error,
    output logic       overrun
);

    // Centre of bit k in clock cycles from the first low cycle; 64-bit so CLOCK_FREQ*19 cannot overflow.
    function automatic longint sample_point(input int k);
        return (longint'(CLOCK_FREQ) * longint'(2 * k + 1)) / (2 * longint'(BAUD_RATE));
    endfunction

    localparam longint S9 = sample_point(9);
    localparam int     TW = $clog2(S9 + 1);

    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        IDLE      = 2'd1,
        RECEIVE   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [7:0]    data_nxt;
    logic          valid_nxt;
    logic          framing_error_nxt;
    logic          overrun_nxt;
    logic          sync_meta;
    logic          line;
    logic [9:0]    hit;

    // Two-flop synchronizer for the asynchronous serial input.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            line      <= 1'b0;
        end else begin
            sync_meta <= rs232_txd;
            line      <= sync_meta;
        end
    end

    // One comparator per sample point; each point is rounded independently so error never accumulates.
    for (genvar k = 0; k < 10; k++) begin : g_sample
        localparam logic [TW-1:0] SK = TW'(sample_point(k));
        assign hit[k] = (timer == SK);
    end

    // Next-state and output decode. The timer reads 0 in the first low cycle (seen in IDLE),
    // so RECEIVE is entered with 1 and the timer always equals cycles since the falling edge.
    always_comb begin
        state_nxt         = state;
        timer_nxt         = timer;
        shift_nxt         = shift;
        data_nxt          = data;
        valid_nxt         = valid && !ready;
        framing_error_nxt = 1'b0;
        overrun_nxt       = 1'b0;
        case (state)
            WAIT_HIGH: begin
                timer_nxt = '0;
                if (line) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                timer_nxt = '0;
                if (!line) begin
                    state_nxt = RECEIVE;
                    timer_nxt = TW'(1);
                end
            end
            RECEIVE: begin
                timer_nxt = timer + TW'(1);
                // Start bit no longer low at its centre: treat as a glitch.
                if (hit[0] && line) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end
                for (int k = 1; k <= 8; k++) begin
                    if (hit[k]) begin
                        shift_nxt[k-1] = line;
                    end
                end
                // Stop bit centre: deliver or drop, then resync immediately without waiting out the stop bit.
                if (hit[9]) begin
                    timer_nxt = '0;
                    if (line) begin
                        state_nxt = IDLE;
                        if (!valid || ready) begin
                            data_nxt  = shift;
                            valid_nxt = 1'b1;
                        end else begin
                            overrun_nxt = 1'b1;
                        end
                    end else begin
                        // Require the line to go high again so a held break reports only once.
                        state_nxt         = WAIT_HIGH;
                        framing_error_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = WAIT_HIGH;
                timer_nxt = '0;
            end
        endcase
    end

    // State, datapath and output registers; cts_n trails the valid register by one cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= WAIT_HIGH;
            timer         <= '0;
            shift         <= '0;
            data          <= '0;
            valid         <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
            rs232_cts_n   <= 1'b1;
        end else begin
            state         <= state_nxt;
            timer         <= timer_nxt;
            shift         <= shift_nxt;
            data          <= data_nxt;
            valid         <= valid_nxt;
            framing_error <= framing_error_nxt;
            overrun       <= overrun_nxt;
            rs232_cts_n   <= valid;
        end
    end

endmodule

// File: tb/tb_rs232_recv.sv
// Directed bench for rs232_recv: one small-ratio instance for exact timing, one at the default rates.
// Latency: n/a.
// Backpressure: ready driven per scenario.
module tb_rs232_recv;

    localparam real BT_A = 12.0;
    localparam real BT_B = 133000000.0 / 115200.0;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;

    logic       txd_a = 1'b1;
    logic       cts_a;
    logic [7:0] data_a;
    logic       valid_a;
    logic       ready_a = 1'b1;
    logic       fe_a;
    logic       ovr_a;

    logic       txd_b = 1'b1;
    logic       cts_b;
    logic [7:0] data_b;
    logic       valid_b;
    logic       ready_b = 1'b1;
    logic       fe_b;
    logic       ovr_b;

    int checks = 0;
    int errors = 0;
    int fe_a_cnt = 0;
    int ovr_a_cnt = 0;
    int fe_b_cnt = 0;
    int ovr_b_cnt = 0;
    logic [7:0] rx_a [$];
    logic [7:0] rx_b [$];

    always #5 clock = ~clock;

    rs232_recv #(.CLOCK_FREQ(12000000), .BAUD_RATE(1000000)) u_dut_a (
        .clock         (clock),
        .reset_n       (reset_n),
        .rs232_txd     (txd_a),
        .rs232_cts_n   (cts_a),
        .data          (data_a),
        .valid         (valid_a),
        .ready         (ready_a),
        .framing_error (fe_a),
        .overrun       (ovr_a)
    );

    rs232_recv #(.CLOCK_FREQ(133000000), .BAUD_RATE(115200)) u_dut_b (
        .clock         (clock),
        .reset_n       (reset_n),
        .rs232_txd     (txd_b),
        .rs232_cts_n   (cts_b),
        .data          (data_b),
        .valid         (valid_b),
        .ready         (ready_b),
        .framing_error (fe_b),
        .overrun       (ovr_b)
    );

    // Record handshakes and error pulses mid-cycle, away from the active edge.
    always @(negedge clock) begin
        if (valid_a === 1'b1 && ready_a === 1'b1) rx_a.push_back(data_a);
        if (valid_b === 1'b1 && ready_b === 1'b1) rx_b.push_back(data_b);
        if (fe_a === 1'b1)  fe_a_cnt++;
        if (ovr_a === 1'b1) ovr_a_cnt++;
        if (fe_b === 1'b1)  fe_b_cnt++;
        if (ovr_b === 1'b1) ovr_b_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Drive one 8N1 frame; bit edges are rounded from the cumulative real bit time.
    task automatic send_frame(input bit sel_b, input logic [7:0] b, input logic stop, input real bt);
        logic [9:0] bits;
        int done;
        int target;
        bits = {stop, b, 1'b0};
        done = 0;
        for (int i = 0; i < 10; i++) begin
            if (sel_b) txd_b = bits[i];
            else       txd_a = bits[i];
            target = $rtoi(bt * real'(i + 1) + 0.5);
            tick(target - done);
            done = target;
        end
    endtask

    task automatic test_reset;
        tick(3);
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", data_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid_a); end
        checks++; if (cts_a !== 1'b1) begin errors++; $display("FAIL rst_cts: got %b want 1", cts_a); end
        checks++; if (fe_a !== 1'b0) begin errors++; $display("FAIL rst_fe: got %b want 0", fe_a); end
        checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL rst_ovr: got %b want 0", ovr_a); end
        reset_n = 1'b1;
        tick(5);
    endtask

    task automatic test_single_frame;
        int base;
        base = rx_a.size();
        ready_a = 1'b1;
        fork
            send_frame(1'b0, 8'hA5, 1'b1, BT_A);
            begin
                tick(116);
                checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL t1_valid_early: got %b want 0", valid_a); end
                tick(1);
                checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL t1_valid_latency: got %b want 1", valid_a); end
                checks++; if (data_a !== 8'hA5) begin errors++; $display("FAIL t1_data: got %h want a5", data_a); end
                checks++; if (cts_a !== 1'b0) begin errors++; $display("FAIL t1_cts_lag: got %b want 0", cts_a); end
                tick(1);
                checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL t1_valid_one_cycle: got %b want 0", valid_a); end
                checks++; if (cts_a !== 1'b1) begin errors++; $display("FAIL t1_cts_high: got %b want 1", cts_a); end
            end
        join
        tick(12);
        checks++;
        if (rx_a.size() != base + 1) begin errors++; $display("FAIL t1_count: got %0d want 1", rx_a.size() - base); end
        else begin
            checks++; if (rx_a[base] !== 8'hA5) begin errors++; $display("FAIL t1_rx: got %h want a5", rx_a[base]); end
        end
    endtask

    task automatic test_glitch;
        int base;
        int fe0;
        base = rx_a.size();
        fe0 = fe_a_cnt;
        txd_a = 1'b0;
        tick(3);
        txd_a = 1'b1;
        tick(30);
        checks++; if (rx_a.size() != base) begin errors++; $display("FAIL t2_no_byte: got %0d want 0", rx_a.size() - base); end
        checks++; if (fe_a_cnt != fe0) begin errors++; $display("FAIL t2_no_fe: got %0d want 0", fe_a_cnt - fe0); end
        send_frame(1'b0, 8'h3C, 1'b1, BT_A);
        tick(12);
        checks++;
        if (rx_a.size() != base + 1) begin errors++; $display("FAIL t2_count: got %0d want 1", rx_a.size() - base); end
        else begin
            checks++; if (rx_a[base] !== 8'h3C) begin errors++; $display("FAIL t2_rx: got %h want 3c", rx_a[base]); end
        end
    endtask

    task automatic test_break;
        int base;
        int fe0;
        base = rx_a.size();
        fe0 = fe_a_cnt;
        send_frame(1'b0, 8'h55, 1'b0, BT_A);
        tick(600);
        txd_a = 1'b1;
        tick(24);
        checks++; if (fe_a_cnt - fe0 != 1) begin errors++; $display("FAIL t3_fe_once: got %0d want 1", fe_a_cnt - fe0); end
        checks++; if (rx_a.size() != base) begin errors++; $display("FAIL t3_no_byte: got %0d want 0", rx_a.size() - base); end
        send_frame(1'b0, 8'h81, 1'b1, BT_A);
        tick(12);
        checks++;
        if (rx_a.size() != base + 1) begin errors++; $display("FAIL t3_count: got %0d want 1", rx_a.size() - base); end
        else begin
            checks++; if (rx_a[base] !== 8'h81) begin errors++; $display("FAIL t3_rx: got %h want 81", rx_a[base]); end
        end
    endtask

    task automatic test_overrun;
        int base;
        int ov0;
        ready_a = 1'b0;
        base = rx_a.size();
        ov0 = ovr_a_cnt;
        send_frame(1'b0, 8'h11, 1'b1, BT_A);
        tick(10);
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL t4_valid: got %b want 1", valid_a); end
        checks++; if (data_a !== 8'h11) begin errors++; $display("FAIL t4_data: got %h want 11", data_a); end
        checks++; if (cts_a !== 1'b1) begin errors++; $display("FAIL t4_cts: got %b want 1", cts_a); end
        send_frame(1'b0, 8'h22, 1'b1, BT_A);
        tick(10);
        checks++; if (ovr_a_cnt - ov0 != 1) begin errors++; $display("FAIL t4_ovr_once: got %0d want 1", ovr_a_cnt - ov0); end
        checks++; if (data_a !== 8'h11) begin errors++; $display("FAIL t4_data_held: got %h want 11", data_a); end
        ready_a = 1'b1;
        tick(3);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL t4_drained: got %b want 0", valid_a); end
        checks++;
        if (rx_a.size() != base + 1) begin errors++; $display("FAIL t4_count: got %0d want 1", rx_a.size() - base); end
        else begin
            checks++; if (rx_a[base] !== 8'h11) begin errors++; $display("FAIL t4_rx: got %h want 11", rx_a[base]); end
        end
    endtask

    task automatic test_ready_on_complete;
        int base;
        int ov0;
        ready_a = 1'b0;
        base = rx_a.size();
        ov0 = ovr_a_cnt;
        send_frame(1'b0, 8'h11, 1'b1, BT_A);
        tick(10);
        fork
            send_frame(1'b0, 8'h22, 1'b1, BT_A);
            begin
                tick(116);
                ready_a = 1'b1;
                tick(1);
                ready_a = 1'b0;
                checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL t5_valid: got %b want 1", valid_a); end
                checks++; if (data_a !== 8'h22) begin errors++; $display("FAIL t5_data: got %h want 22", data_a); end
            end
        join
        tick(5);
        checks++; if (ovr_a_cnt != ov0) begin errors++; $display("FAIL t5_no_ovr: got %0d want 0", ovr_a_cnt - ov0); end
        checks++;
        if (rx_a.size() != base + 1) begin errors++; $display("FAIL t5_count: got %0d want 1", rx_a.size() - base); end
        else begin
            checks++; if (rx_a[base] !== 8'h11) begin errors++; $display("FAIL t5_rx_first: got %h want 11", rx_a[base]); end
        end
        ready_a = 1'b1;
        tick(3);
        checks++;
        if (rx_a.size() != base + 2) begin errors++; $display("FAIL t5_count2: got %0d want 2", rx_a.size() - base); end
        else begin
            checks++; if (rx_a[base+1] !== 8'h22) begin errors++; $display("FAIL t5_rx_second: got %h want 22", rx_a[base+1]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_b [4];
        int base;
        int fe0;
        int ov0;
        exp_b[0] = 8'h0F;
        exp_b[1] = 8'hF0;
        exp_b[2] = 8'hA5;
        exp_b[3] = 8'h5A;
        ready_b = 1'b1;
        base = rx_b.size();
        fe0 = fe_b_cnt;
        ov0 = ovr_b_cnt;
        for (int i = 0; i < 4; i++) begin
            send_frame(1'b1, exp_b[i], 1'b1, (i < 2) ? BT_B * 0.98 : BT_B * 1.02);
        end
        tick(200);
        checks++; if (fe_b_cnt != fe0) begin errors++; $display("FAIL t6_no_fe: got %0d want 0", fe_b_cnt - fe0); end
        checks++; if (ovr_b_cnt != ov0) begin errors++; $display("FAIL t6_no_ovr: got %0d want 0", ovr_b_cnt - ov0); end
        checks++;
        if (rx_b.size() != base + 4) begin errors++; $display("FAIL t6_count: got %0d want 4", rx_b.size() - base); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rx_b[base+i] !== exp_b[i]) begin errors++; $display("FAIL t6_rx%0d: got %h want %h", i, rx_b[base+i], exp_b[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int base;
        int fe0;
        ready_b = 1'b0;
        send_frame(1'b1, 8'h96, 1'b1, BT_B);
        tick(20);
        checks++; if (valid_b !== 1'b1) begin errors++; $display("FAIL t7_pending_valid: got %b want 1", valid_b); end
        checks++; if (data_b !== 8'h96) begin errors++; $display("FAIL t7_pending_data: got %h want 96", data_b); end
        checks++; if (cts_b !== 1'b1) begin errors++; $display("FAIL t7_pending_cts: got %b want 1", cts_b); end
        base = rx_b.size();
        fe0 = fe_b_cnt;
        txd_b = 1'b0;
        tick(2500);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL t7_rst_valid: got %b want 0", valid_b); end
        checks++; if (data_b !== 8'h00) begin errors++; $display("FAIL t7_rst_data: got %h want 00", data_b); end
        checks++; if (cts_b !== 1'b1) begin errors++; $display("FAIL t7_rst_cts: got %b want 1", cts_b); end
        checks++; if (fe_b !== 1'b0 || ovr_b !== 1'b0) begin errors++; $display("FAIL t7_rst_err: got fe=%b ovr=%b want 0 0", fe_b, ovr_b); end
        tick(3);
        reset_n = 1'b1;
        ready_b = 1'b1;
        tick(1000);
        txd_b = 1'b1;
        tick(2500);
        checks++; if (rx_b.size() != base) begin errors++; $display("FAIL t7_no_byte: got %0d want 0", rx_b.size() - base); end
        checks++; if (fe_b_cnt != fe0) begin errors++; $display("FAIL t7_no_fe: got %0d want 0", fe_b_cnt - fe0); end
        checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL t7_valid_after: got %b want 0", valid_b); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_break();
        test_overrun();
        test_ready_on_complete();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
